// File: rtl/mi2c_pkg.sv
// mi2c_pkg: command encodings shared by mi2c_ctrl and mi2c_drive, plus the
// transaction phase enum used by mi2c_ctrl.
package mi2c_pkg;

  // One-hot driver commands.
  localparam logic [5:0] CMD_IDLE = 6'b000000;
  localparam logic [5:0] CMD_STAR = 6'b000001;
  localparam logic [5:0] CMD_WR   = 6'b000010;
  localparam logic [5:0] CMD_GACK = 6'b000100;
  localparam logic [5:0] CMD_RD   = 6'b001000;
  localparam logic [5:0] CMD_OACK = 6'b010000;
  localparam logic [5:0] CMD_STOP = 6'b100000;

  typedef enum logic [3:0] {
    P_IDLE,
    P_START,
    P_DEVW,
    P_ACKD,
    P_REG,
    P_ACKR,
    P_WDAT,
    P_ACKW,
    P_RSTART,
    P_DEVR,
    P_ACKDR,
    P_RDAT,
    P_OACK,
    P_STOP
  } phase_e;

  // Driver command issued for each phase.
  function automatic logic [5:0] phase_cmd(input phase_e ph);
    case (ph)
      P_START, P_RSTART:             phase_cmd = CMD_STAR;
      P_DEVW, P_REG, P_WDAT, P_DEVR: phase_cmd = CMD_WR;
      P_ACKD, P_ACKR, P_ACKW, P_ACKDR: phase_cmd = CMD_GACK;
      P_RDAT:                        phase_cmd = CMD_RD;
      P_OACK:                        phase_cmd = CMD_OACK;
      P_STOP:                        phase_cmd = CMD_STOP;
      default:                       phase_cmd = CMD_IDLE;
    endcase
  endfunction

  // Phases whose completion carries a slave ACK/NACK.
  function automatic logic is_gack(input phase_e ph);
    return (ph == P_ACKD) || (ph == P_ACKR) || (ph == P_ACKW) || (ph == P_ACKDR);
  endfunction

endpackage

// File: rtl/mi2c_ctrl.sv
// mi2c_ctrl: expands one register read/write request into the one-hot
// command stream consumed by mi2c_drive. Optional macro MI2C_CTRL_REG16_EN
// widens the register address to 16 bits (sent MSB byte first).
module mi2c_ctrl
  import mi2c_pkg::*;
#(
  parameter int unsigned LEN_W = 4,
  parameter int unsigned CMD_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_rw_i,
  input  logic [6:0]       dev_addr_i,
`ifdef MI2C_CTRL_REG16_EN
  input  logic [15:0]      reg_addr_i,
`else
  input  logic [7:0]       reg_addr_i,
`endif
  input  logic [LEN_W-1:0] len_i,
  output logic             wr_req_o,
  input  logic [7:0]       wr_data_i,
  output logic             rd_valid_o,
  output logic [7:0]       rd_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             cmd_en_o,
  output logic [CMD_W-1:0] cmd_sta_o,
  output logic [7:0]       tx_data_o,
  output logic             rd_over_o,
  input  logic             cmd_done_i,
  input  logic             slave_ack_i,
  input  logic [7:0]       rd_data_i
);

`ifdef MI2C_CTRL_REG16_EN
  localparam int unsigned REG_W = 16;
`else
  localparam int unsigned REG_W = 8;
`endif

  phase_e           phase_q;
  logic             issue_q;    // 1: issue sub-step, 0: waiting for cmd_done_i
  logic [LEN_W-1:0] cnt_q;
  logic [6:0]       dev_q;
  logic [REG_W-1:0] reg_q;
  logic             rw_q;
  logic             wr_pend_q;  // wr_data_i is valid this cycle
`ifdef MI2C_CTRL_REG16_EN
  logic             reg_lsb_q;  // second (LSB) register byte in progress
`endif

  // Phase sequencer with all outputs registered.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= P_IDLE;
      issue_q     <= 1'b0;
      cnt_q       <= '0;
      dev_q       <= '0;
      reg_q       <= '0;
      rw_q        <= 1'b0;
      wr_pend_q   <= 1'b0;
`ifdef MI2C_CTRL_REG16_EN
      reg_lsb_q   <= 1'b0;
`endif
      req_ready_o <= 1'b1;
      wr_req_o    <= 1'b0;
      rd_valid_o  <= 1'b0;
      rd_data_o   <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      cmd_en_o    <= 1'b0;
      cmd_sta_o   <= '0;
      tx_data_o   <= '0;
      rd_over_o   <= 1'b0;
    end else begin
      cmd_en_o   <= 1'b0;
      wr_req_o   <= 1'b0;
      rd_valid_o <= 1'b0;
      done_o     <= 1'b0;
      wr_pend_q  <= wr_req_o;
      if (wr_pend_q) tx_data_o <= wr_data_i;

      if (phase_q == P_IDLE) begin
        if (req_valid_i && req_ready_o) begin
          dev_q       <= dev_addr_i;
          reg_q       <= reg_addr_i;
          rw_q        <= req_rw_i;
          cnt_q       <= len_i;
          err_o       <= 1'b0;
          busy_o      <= 1'b1;
          req_ready_o <= 1'b0;
          phase_q     <= P_START;
          issue_q     <= 1'b1;
`ifdef MI2C_CTRL_REG16_EN
          reg_lsb_q   <= 1'b0;
`endif
        end
      end else if (issue_q) begin
        issue_q   <= 1'b0;
        cmd_en_o  <= 1'b1;
        cmd_sta_o <= CMD_W'(phase_cmd(phase_q));
        // tx_data_o is staged one command ahead of the WR that ships it.
        case (phase_q)
          P_START:  tx_data_o <= {dev_q, 1'b0};
          P_ACKD:   tx_data_o <= reg_q[REG_W-1 -: 8];
          P_ACKR: begin
`ifdef MI2C_CTRL_REG16_EN
            if (!reg_lsb_q) tx_data_o <= reg_q[7:0];
            else if (!rw_q) wr_req_o <= 1'b1;
`else
            if (!rw_q) wr_req_o <= 1'b1;
`endif
          end
          P_ACKW:   if (cnt_q != '0) wr_req_o <= 1'b1;
          P_RSTART: tx_data_o <= {dev_q, 1'b1};
          P_OACK:   rd_over_o <= (cnt_q == '0);
          default:  ;
        endcase
      end else if (cmd_done_i && !cmd_en_o && !wr_pend_q) begin
        // A done in the issue cycle, or before the pulled write byte lands, is ignored.
        issue_q <= 1'b1;
        if (is_gack(phase_q) && slave_ack_i) begin
          err_o   <= 1'b1;
          phase_q <= P_STOP;
        end else begin
          case (phase_q)
            P_START:  phase_q <= P_DEVW;
            P_DEVW:   phase_q <= P_ACKD;
            P_ACKD:   phase_q <= P_REG;
            P_REG:    phase_q <= P_ACKR;
            P_ACKR: begin
`ifdef MI2C_CTRL_REG16_EN
              if (!reg_lsb_q) begin
                reg_lsb_q <= 1'b1;
                phase_q   <= P_REG;
              end else begin
                phase_q <= rw_q ? P_RSTART : P_WDAT;
              end
`else
              phase_q <= rw_q ? P_RSTART : P_WDAT;
`endif
            end
            P_WDAT:   phase_q <= P_ACKW;
            P_ACKW: begin
              if (cnt_q == '0) begin
                phase_q <= P_STOP;
              end else begin
                cnt_q   <= cnt_q - 1'b1;
                phase_q <= P_WDAT;
              end
            end
            P_RSTART: phase_q <= P_DEVR;
            P_DEVR:   phase_q <= P_ACKDR;
            P_ACKDR:  phase_q <= P_RDAT;
            P_RDAT: begin
              rd_data_o  <= rd_data_i;
              rd_valid_o <= 1'b1;
              phase_q    <= P_OACK;
            end
            P_OACK: begin
              if (cnt_q == '0) begin
                phase_q <= P_STOP;
              end else begin
                cnt_q   <= cnt_q - 1'b1;
                phase_q <= P_RDAT;
              end
            end
            P_STOP: begin
              phase_q     <= P_IDLE;
              issue_q     <= 1'b0;
              done_o      <= 1'b1;
              busy_o      <= 1'b0;
              req_ready_o <= 1'b1;
              cmd_sta_o   <= CMD_W'(CMD_IDLE);
            end
            default:  phase_q <= P_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_mi2c_ctrl.sv
// tb_mi2c_ctrl: scoreboard bench for mi2c_ctrl with a behavioural driver model.
// Honours MI2C_CTRL_REG16_EN for the register address width.
module tb_mi2c_ctrl;
  import mi2c_pkg::*;

  localparam int LEN_W = 4;
  localparam int CMD_W = 6;
`ifdef MI2C_CTRL_REG16_EN
  localparam int REG_W = 16;
`else
  localparam int REG_W = 8;
`endif

  logic             clk_i = 1'b0;
  logic             rst_n;
  logic             req_valid_i;
  logic             req_ready_o;
  logic             req_rw_i;
  logic [6:0]       dev_addr_i;
  logic [REG_W-1:0] reg_addr_i;
  logic [LEN_W-1:0] len_i;
  logic             wr_req_o;
  logic [7:0]       wr_data_i;
  logic             rd_valid_o;
  logic [7:0]       rd_data_o;
  logic             busy_o;
  logic             done_o;
  logic             err_o;
  logic             cmd_en_o;
  logic [CMD_W-1:0] cmd_sta_o;
  logic [7:0]       tx_data_o;
  logic             rd_over_o;
  logic             cmd_done_i;
  logic             slave_ack_i;
  logic [7:0]       rd_data_i;

  mi2c_ctrl #(.LEN_W(LEN_W), .CMD_W(CMD_W)) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_rw_i(req_rw_i),
    .dev_addr_i(dev_addr_i), .reg_addr_i(reg_addr_i), .len_i(len_i),
    .wr_req_o(wr_req_o), .wr_data_i(wr_data_i),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .cmd_en_o(cmd_en_o), .cmd_sta_o(cmd_sta_o), .tx_data_o(tx_data_o),
    .rd_over_o(rd_over_o), .cmd_done_i(cmd_done_i), .slave_ack_i(slave_ack_i),
    .rd_data_i(rd_data_i)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Scoreboard queues filled by stimulus, drained by the monitor.
  logic [5:0] exp_cmd[$];
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rd[$];
  logic       exp_over[$];
  logic       exp_err[$];
  // Data sources for the DUT write pull and the driver model reads.
  logic [7:0] wr_src[$];
  logic [7:0] rd_src[$];

  int done_cnt = 0;
  int accept_cnt = 0;
  int acc_at_done = 0;
  int wr_req_cnt = 0;
  int wr_cmd_cnt = 0;
  int gack_cnt = 0;
  int nack_idx = 0;
  logic [7:0] drv_tx = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got 0x%0h required nothing", name, act);
  endtask

  // Monitor: compares every DUT presentation against the scoreboard.
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_n) begin
        if (cmd_en_o) begin
          if (exp_cmd.size() == 0) fail_msg("unexpected_cmd", 32'(cmd_sta_o));
          else chk("cmd_order", 32'(cmd_sta_o), 32'(exp_cmd.pop_front()));
          if (cmd_sta_o == CMD_WR) begin
            wr_cmd_cnt++;
            if (exp_tx.size() == 0) fail_msg("unexpected_wr", 32'(drv_tx));
            else chk("wr_byte", 32'(drv_tx), 32'(exp_tx.pop_front()));
          end
          if (cmd_sta_o == CMD_OACK) begin
            if (exp_over.size() == 0) fail_msg("unexpected_oack", 32'(rd_over_o));
            else chk("rd_over", 32'(rd_over_o), 32'(exp_over.pop_front()));
          end
        end
        if (rd_valid_o) begin
          if (exp_rd.size() == 0) fail_msg("unexpected_rd", 32'(rd_data_o));
          else chk("rd_data", 32'(rd_data_o), 32'(exp_rd.pop_front()));
        end
        if (done_o) begin
          done_cnt++;
          acc_at_done = accept_cnt;
          if (exp_err.size() == 0) fail_msg("unexpected_done", 32'(err_o));
          else chk("done_err", 32'(err_o), 32'(exp_err.pop_front()));
        end
        if (req_valid_i && req_ready_o) accept_cnt++;
      end
    end
  end

  // Write-byte source answering wr_req_o.
  initial begin
    wr_data_i = 8'h00;
    forever begin
      @(negedge clk_i);
      if (rst_n && wr_req_o) begin
        wr_req_cnt++;
        if (wr_src.size() > 0) wr_data_i = wr_src.pop_front();
        else fail_msg("unexpected_wr_req", 32'(wr_req_cnt));
      end
    end
  end

  // Driver model: completes each command 3 cycles after issue, latching tx_data_o.
  initial begin
    logic       busy;
    int         wait_n;
    logic [5:0] cmd;
    busy = 1'b0; wait_n = 0; cmd = CMD_IDLE;
    cmd_done_i = 1'b0; slave_ack_i = 1'b0; rd_data_i = 8'h00;
    forever begin
      @(negedge clk_i);
      cmd_done_i = 1'b0;
      slave_ack_i = 1'b0;
      if (!rst_n) begin
        busy = 1'b0;
      end else if (busy) begin
        if (wait_n != 0) begin
          wait_n--;
        end else begin
          busy = 1'b0;
          cmd_done_i = 1'b1;
          drv_tx = tx_data_o;
          if (cmd == CMD_GACK) begin
            gack_cnt++;
            slave_ack_i = (gack_cnt == nack_idx);
          end
          if (cmd == CMD_RD && rd_src.size() > 0) rd_data_i = rd_src.pop_front();
        end
      end
      if (rst_n && cmd_en_o) begin
        busy = 1'b1;
        wait_n = 2;
        cmd = cmd_sta_o;
      end
    end
  end

  // Expected-stream builders.
  task automatic exp_hdr(input logic [6:0] dev, input logic [REG_W-1:0] rg);
    exp_cmd.push_back(CMD_STAR);
    exp_cmd.push_back(CMD_WR); exp_tx.push_back({dev, 1'b0});
    exp_cmd.push_back(CMD_GACK);
    for (int i = REG_W / 8 - 1; i >= 0; i--) begin
      exp_cmd.push_back(CMD_WR); exp_tx.push_back(rg[i*8 +: 8]);
      exp_cmd.push_back(CMD_GACK);
    end
  endtask

  task automatic exp_wbyte(input logic [7:0] b);
    wr_src.push_back(b);
    exp_cmd.push_back(CMD_WR); exp_tx.push_back(b);
    exp_cmd.push_back(CMD_GACK);
  endtask

  task automatic exp_rhdr(input logic [6:0] dev);
    exp_cmd.push_back(CMD_STAR);
    exp_cmd.push_back(CMD_WR); exp_tx.push_back({dev, 1'b1});
    exp_cmd.push_back(CMD_GACK);
  endtask

  task automatic exp_rbyte(input logic [7:0] b, input logic last);
    rd_src.push_back(b);
    exp_cmd.push_back(CMD_RD); exp_rd.push_back(b);
    exp_cmd.push_back(CMD_OACK); exp_over.push_back(last);
  endtask

  task automatic exp_stop(input logic err);
    exp_cmd.push_back(CMD_STOP);
    exp_err.push_back(err);
  endtask

  task automatic send(input logic rw, input logic [6:0] dev, input logic [REG_W-1:0] rg,
                      input logic [LEN_W-1:0] len);
    int n;
    @(posedge clk_i); #1;
    req_rw_i = rw; dev_addr_i = dev; reg_addr_i = rg; len_i = len; req_valid_i = 1'b1;
    n = 0;
    do begin
      @(posedge clk_i); #1;
      n++;
    end while (req_ready_o && n < 20);
    if (req_ready_o) fail_msg("accept_timeout", 32'(n));
    req_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int n;
    n = 0;
    while (done_cnt < target && n < 2000) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (done_cnt < target) fail_msg(name, 32'(done_cnt));
  endtask

  task automatic chk_drained(input string name);
    chk(name, 32'(exp_cmd.size() + exp_tx.size() + exp_rd.size() + exp_over.size() +
                  exp_err.size() + wr_src.size() + rd_src.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, 32'({req_ready_o, busy_o, done_o, err_o, cmd_en_o, wr_req_o, rd_valid_o,
                   rd_over_o, cmd_sta_o, tx_data_o, rd_data_o}), 32'h2000_0000);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int n;
    rst_n = 1'b0;
    req_valid_i = 1'b0; req_rw_i = 1'b0; dev_addr_i = '0; reg_addr_i = '0; len_i = '0;
    #12;
    chk_reset_outputs("reset_state");
    #5 rst_n = 1'b1;

    // Write burst of two bytes.
    gack_cnt = 0; nack_idx = 0;
    exp_hdr(7'h50, REG_W'(8'h10));
    exp_wbyte(8'hA5);
    exp_wbyte(8'h3C);
    exp_stop(1'b0);
    base = wr_req_cnt;
    send(1'b0, 7'h50, REG_W'(8'h10), 4'd1);
    chk("busy_during_write", 32'({busy_o, req_ready_o}), 32'b10);
    wait_done(1, "write_done_timeout");
    chk("write_wr_req_count", 32'(wr_req_cnt - base), 32'd2);
    chk_drained("write_drained");

    // Read burst of three bytes.
    gack_cnt = 0;
    exp_hdr(7'h50, REG_W'(8'h02));
    exp_rhdr(7'h50);
    exp_rbyte(8'h11, 1'b0);
    exp_rbyte(8'h22, 1'b0);
    exp_rbyte(8'h33, 1'b1);
    exp_stop(1'b0);
    send(1'b1, 7'h50, REG_W'(8'h02), 4'd2);
    wait_done(2, "read_done_timeout");
    chk_drained("read_drained");

    // NACK on the device-address GACK.
    gack_cnt = 0; nack_idx = 1;
    exp_cmd.push_back(CMD_STAR);
    exp_cmd.push_back(CMD_WR); exp_tx.push_back(8'hA0);
    exp_cmd.push_back(CMD_GACK);
    exp_stop(1'b1);
    base = wr_req_cnt;
    send(1'b0, 7'h50, REG_W'(8'h10), 4'd0);
    wait_done(3, "nack_done_timeout");
    nack_idx = 0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("nack_err_held", 32'({err_o, busy_o}), 32'b10);
    chk("nack_wr_req_count", 32'(wr_req_cnt - base), 32'd0);
    chk_drained("nack_drained");

    // Asynchronous reset during the first WDAT of a four-byte write.
    gack_cnt = 0;
    exp_hdr(7'h50, REG_W'(8'h10));
    exp_wbyte(8'h01); exp_wbyte(8'h02); exp_wbyte(8'h03); exp_wbyte(8'h04);
    exp_stop(1'b0);
    base = wr_cmd_cnt;
    send(1'b0, 7'h50, REG_W'(8'h10), 4'd3);
    n = 0;
    while (wr_cmd_cnt < base + 2 + REG_W / 8 && n < 500) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (wr_cmd_cnt < base + 2 + REG_W / 8) fail_msg("wdat_reach_timeout", 32'(wr_cmd_cnt));
    chk("err_cleared_on_accept", 32'({err_o, busy_o}), 32'b01);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midwdat_reset_state");
    exp_cmd.delete(); exp_tx.delete(); exp_rd.delete(); exp_over.delete();
    exp_err.delete(); wr_src.delete(); rd_src.delete();
    repeat (2) @(posedge clk_i);
    #1 rst_n = 1'b1;
    chk_reset_outputs("after_reset_release");
    gack_cnt = 0;
    exp_hdr(7'h2A, REG_W'(8'h81));
    exp_wbyte(8'hC3);
    exp_stop(1'b0);
    send(1'b0, 7'h2A, REG_W'(8'h81), 4'd0);
    wait_done(4, "post_reset_done_timeout");
    chk_drained("post_reset_drained");

    // req_valid_i held through a transaction: exactly one accept per idle window.
    gack_cnt = 0;
    exp_hdr(7'h33, REG_W'(8'h44)); exp_wbyte(8'h5A); exp_stop(1'b0);
    exp_hdr(7'h33, REG_W'(8'h44)); exp_wbyte(8'h6B); exp_stop(1'b0);
    base = accept_cnt;
    @(posedge clk_i); #1;
    req_rw_i = 1'b0; dev_addr_i = 7'h33; reg_addr_i = REG_W'(8'h44); len_i = 4'd0;
    req_valid_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    chk("hold_ready_low_while_busy", 32'({req_ready_o, busy_o}), 32'b01);
    wait_done(5, "hold_first_done_timeout");
    chk("hold_single_accept", 32'(acc_at_done - base), 32'd1);
    n = 0;
    while (req_ready_o && n < 20) begin
      @(posedge clk_i); #1;
      n++;
    end
    req_valid_i = 1'b0;
    wait_done(6, "hold_second_done_timeout");
    chk("hold_total_accepts", 32'(accept_cnt - base), 32'd2);
    chk_drained("hold_drained");

    // Wide register address (two REG bytes when MI2C_CTRL_REG16_EN is defined).
    gack_cnt = 0;
    exp_hdr(7'h50, REG_W'(16'h1234));
    exp_wbyte(8'h77);
    exp_stop(1'b0);
    send(1'b0, 7'h50, REG_W'(16'h1234), 4'd0);
    wait_done(7, "reg_wide_done_timeout");
    chk_drained("reg_wide_drained");
    repeat (2) @(posedge clk_i);
    #1;
    chk("idle_after_all", 32'({req_ready_o, busy_o, cmd_sta_o}), 32'({1'b1, 1'b0, CMD_IDLE}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
